// File: rtl/sf_pkg.sv
// Shared SF cell definitions: operation codes and next-state rule.
package sf_pkg;

  // Bit 1 = S, bit 0 = F
  typedef enum logic [1:0] {
    SF_CLEAR  = 2'b00,
    SF_SET    = 2'b01,
    SF_HOLD   = 2'b10,
    SF_TOGGLE = 2'b11
  } sf_op_t;

  function automatic logic sf_next(input sf_op_t op, input logic q);
    logic nq;
    case (op)
      SF_CLEAR:  nq = 1'b0;
      SF_SET:    nq = 1'b1;
      SF_HOLD:   nq = q;
      SF_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sf_cell.sv
// Single SF flip-flop; clears to 0 on asynchronous active-low reset.
module sf_cell
  import sf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic f,
  output logic q
);

  // Apply the SF rule selected by {s, f} every rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= sf_next(sf_op_t'({s, f}), q);
  end

endmodule

// File: rtl/sf_bank_arbiter.sv
// Round-robin access controller for a bank of SF cells.
// At most one operation per clock is accepted and applied to one cell;
// a registered response follows one cycle later.
module sf_bank_arbiter
  import sf_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [IDXW*NREQ-1:0]      req_idx,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          q,
  output logic                      resp_valid,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic                      resp_q,
  output logic                      err
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_id;
  logic            accept;
  sf_op_t          sel_op;
  logic [IDXW-1:0] sel_idx;
  logic            in_range;
  logic            cur_q;
  logic            new_q;
  int unsigned     j;

  // Round-robin search starting at rr_ptr; capture the winner's op and index
  always_comb begin
    accept   = 1'b0;
    grant_id = '0;
    sel_op   = SF_HOLD;
    sel_idx  = '0;
    j        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr) + k) % NREQ;
      if (!accept && req_valid[PW'(j)]) begin
        accept   = 1'b1;
        grant_id = PW'(j);
        sel_op   = sf_op_t'(req_op[2*j +: 2]);
        sel_idx  = req_idx[IDXW*j +: IDXW];
      end
    end
    req_ready = accept ? (NREQ'(1) << grant_id) : '0;
  end

  // Resolve the addressed cell's current and next value; out-of-range reads as 0
  always_comb begin
    in_range = 32'(sel_idx) < WIDTH;
    cur_q    = 1'b0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      if (sel_idx == IDXW'(c)) cur_q = q[c];
    end
    new_q = in_range ? sf_next(sel_op, cur_q) : 1'b0;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    sf_op_t cell_op;
    assign cell_op = (accept && in_range && sel_idx == IDXW'(g)) ? sel_op : SF_HOLD;
    sf_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (cell_op[1]),
      .f     (cell_op[0]),
      .q     (q[g])
    );
  end

  // Advance the pointer past the winner and register the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_q     <= 1'b0;
      err        <= 1'b0;
    end else begin
      resp_valid <= accept;
      resp_q     <= accept & new_q;
      err        <= accept & ~in_range;
      if (accept) begin
        rr_ptr  <= (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        resp_id <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_sf_bank_arbiter.sv
// Directed bench for sf_bank_arbiter: WIDTH=8 main instance plus a WIDTH=6
// instance sharing the same stimulus for the out-of-range case.
module tb_sf_bank_arbiter;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_HLD = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_op;
  logic [11:0] req_idx;

  logic [3:0] req_ready;
  logic [7:0] q;
  logic       resp_valid;
  logic [1:0] resp_id;
  logic       resp_q;
  logic       err;

  logic [3:0] req_ready6;
  logic [5:0] q6;
  logic       resp_valid6;
  logic [1:0] resp_id6;
  logic       resp_q6;
  logic       err6;

  int n_cmp;
  int n_bad;

  sf_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .q(q), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_q(resp_q), .err(err)
  );

  sf_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready6), .q(q6), .resp_valid(resp_valid6),
    .resp_id(resp_id6), .resp_q(resp_q6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] idx);
    req_valid[i]          = 1'b1;
    req_op[2*i +: 2]      = op;
    req_idx[3*i +: 3]     = idx;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_op    = '0;
    req_idx   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Expect a response for requester id with new cell value rq
  task automatic check_resp(input string tag, input logic [1:0] id, input logic rq);
    check_val({tag, ".rv"}, 32'(resp_valid), 32'd1);
    check_val({tag, ".id"}, 32'(resp_id), 32'(id));
    check_val({tag, ".rq"}, 32'(resp_q), 32'(rq));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clr_all();

    // Reset state, before any clock edge
    #3;
    check_val("rst.q", 32'(q), 32'h00);
    check_val("rst.ready", 32'(req_ready), 32'h0);
    check_val("rst.rv", 32'(resp_valid), 32'd0);
    check_val("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: nothing changes
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("idle.q", 32'(q), 32'h00);
      check_val("idle.rv", 32'(resp_valid), 32'd0);
      check_val("idle.ready", 32'(req_ready), 32'h0);
    end

    // Single requester: SET, TOGGLE, CLEAR on cell 3
    set_req(0, OP_SET, 3'd3);
    #1 check_val("single.ready", 32'(req_ready), 32'h1);
    step();
    check_val("single.set.q", 32'(q), 32'h08);
    check_resp("single.set", 2'd0, 1'b1);
    set_req(0, OP_TGL, 3'd3);
    step();
    check_val("single.tgl.q", 32'(q), 32'h00);
    check_resp("single.tgl", 2'd0, 1'b0);
    set_req(0, OP_CLR, 3'd3);
    step();
    check_val("single.clr.q", 32'(q), 32'h00);
    check_resp("single.clr", 2'd0, 1'b0);
    clr_all();
    step();
    check_val("single.end.rv", 32'(resp_valid), 32'd0);

    // Round-robin from a fresh pointer: all four SET idx 0..3, twice around
    do_reset();
    for (int r = 0; r < 4; r++) set_req(r, OP_SET, 3'(r));
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < 4; r++) begin
        #1 check_val("rr.ready", 32'(req_ready), 32'(4'b0001 << r));
        step();
        check_resp("rr", 2'(r), 1'b1);
      end
      check_val("rr.q", 32'(q), 32'h0F);
    end
    clr_all();

    // Pointer fairness: req1 granted, then req3 ahead of req1
    set_req(1, OP_SET, 3'd4);
    set_req(3, OP_SET, 3'd6);
    #1 check_val("fair.ready1", 32'(req_ready), 32'h2);
    step();
    check_resp("fair.g1", 2'd1, 1'b1);
    check_val("fair.ready3", 32'(req_ready), 32'h8);
    step();
    check_resp("fair.g3", 2'd3, 1'b1);
    check_val("fair.q", 32'(q), 32'h5F);
    clr_all();

    // HOLD then TOGGLE twice on cell 5, starting from q=0x20
    do_reset();
    set_req(0, OP_SET, 3'd5);
    step();
    check_val("ht.init.q", 32'(q), 32'h20);
    clr_all();
    set_req(2, OP_HLD, 3'd5);
    #1 check_val("ht.ready", 32'(req_ready), 32'h4);
    step();
    check_val("ht.hold.q", 32'(q), 32'h20);
    check_resp("ht.hold", 2'd2, 1'b1);
    set_req(2, OP_TGL, 3'd5);
    step();
    check_val("ht.tgl1.q", 32'(q), 32'h00);
    check_resp("ht.tgl1", 2'd2, 1'b0);
    step();
    check_val("ht.tgl2.q", 32'(q), 32'h20);
    check_resp("ht.tgl2", 2'd2, 1'b1);
    clr_all();

    // Out-of-range index on the WIDTH=6 instance (pointer at 3 -> req0 wins)
    set_req(0, OP_SET, 3'd7);
    #1 check_val("err.ready6", 32'(req_ready6), 32'h1);
    step();
    check_val("err.q6", 32'(q6), 32'h20);
    check_val("err.rv6", 32'(resp_valid6), 32'd1);
    check_val("err.err6", 32'(err6), 32'd1);
    check_val("err.rq6", 32'(resp_q6), 32'd0);
    check_val("err.q8", 32'(q), 32'hA0);
    check_val("err.err8", 32'(err), 32'd0);
    clr_all();
    step();
    check_val("err.after.err6", 32'(err6), 32'd0);
    check_val("err.after.rv6", 32'(resp_valid6), 32'd0);

    // Reset mid-stream: accepted op's response is dropped
    set_req(1, OP_SET, 3'd1);
    step();
    check_val("mid.rv", 32'(resp_valid), 32'd1);
    set_req(2, OP_SET, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid.q", 32'(q), 32'h00);
    check_val("mid.rv0", 32'(resp_valid), 32'd0);
    clr_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_val("mid.after.rv", 32'(resp_valid), 32'd0);
    check_val("mid.after.q", 32'(q), 32'h00);

    // First cycle after release arbitrates from requester 0
    for (int r = 0; r < 4; r++) set_req(r, OP_SET, 3'd7);
    #1 check_val("post.ready", 32'(req_ready), 32'h1);
    step();
    check_resp("post", 2'd0, 1'b1);
    clr_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
